// File: rtl/sprite_motion_ctrl.sv
// Player-sprite position controller: rate-limited, clamped key motion,
// a timed rise/fall jump FSM and a warp handshake for stage changes.
module sprite_motion_ctrl #(
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 620,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 460,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 1,
  parameter int JUMP_H   = 40,
  parameter int RST_X    = 320,
  parameter int RST_Y    = 240
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_jump,
  input  logic          warp_valid,
  input  logic [XW-1:0] warp_x,
  input  logic [YW-1:0] warp_y,
  output logic          warp_ack,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          dir,
  output logic          jumping
);

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_e;

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  state_e        state_q;
  logic [CW-1:0] tick_cnt_q;
  logic [XW-1:0] pos_x_q;
  logic [YW-1:0] pos_y_q;
  logic [YW-1:0] base_y_q;
  logic [YW:0]   height_q;
  logic          jump_prev_q;
  logic          dir_q;
  logic          warp_ack_q;

  logic          tick;
  logic          jump_edge;
  logic          move_left;
  logic          move_right;
  logic          move_up;
  logic          move_down;
  logic [XW-1:0] x_left_d;
  logic [XW-1:0] x_right_d;
  logic [YW-1:0] y_up_d;
  logic [YW-1:0] y_down_d;
  logic [YW-1:0] y_fall_d;
  logic [YW:0]   height_d;
  logic          rise_done;
  logic [XW-1:0] warp_x_d;
  logic [YW-1:0] warp_y_d;

  // Signed int arithmetic so a step below zero shows up as negative, not a wrap.
  function automatic logic [XW-1:0] clamp_x(input int v);
    if (v < X_MIN)      return X_MIN[XW-1:0];
    else if (v > X_MAX) return X_MAX[XW-1:0];
    else                return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input int v);
    if (v < Y_MIN)      return Y_MIN[YW-1:0];
    else if (v > Y_MAX) return Y_MAX[YW-1:0];
    else                return v[YW-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    int x_dec, x_inc, y_dec, y_inc, h_inc;
    tick       = (tick_cnt_q == TICK_LAST);
    jump_edge  = key_jump & ~jump_prev_q;
    move_left  = key_left & ~key_right;
    move_right = key_right & ~key_left;
    move_up    = key_up & ~key_down;
    move_down  = key_down & ~key_up;

    x_dec     = int'(pos_x_q) - STEP;
    x_inc     = int'(pos_x_q) + STEP;
    y_dec     = int'(pos_y_q) - STEP;
    y_inc     = int'(pos_y_q) + STEP;
    h_inc     = int'(height_q) + STEP;

    x_left_d  = clamp_x(x_dec);
    x_right_d = clamp_x(x_inc);
    y_up_d    = clamp_y(y_dec);
    y_down_d  = clamp_y(y_inc);
    y_fall_d  = (y_down_d > base_y_q) ? base_y_q : y_down_d;
    height_d  = h_inc[YW:0];
    rise_done = (h_inc >= JUMP_H) || (y_dec <= Y_MIN);

    warp_x_d  = clamp_x(int'(warp_x));
    warp_y_d  = clamp_y(int'(warp_y));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      pos_x_q     <= RST_X[XW-1:0];
      pos_y_q     <= RST_Y[YW-1:0];
      base_y_q    <= RST_Y[YW-1:0];
      height_q    <= '0;
      jump_prev_q <= 1'b0;
      dir_q       <= 1'b0;
      warp_ack_q  <= 1'b0;
    end else begin
      jump_prev_q <= key_jump;
      warp_ack_q  <= warp_valid;
      if (warp_valid) begin
        pos_x_q    <= warp_x_d;
        pos_y_q    <= warp_y_d;
        state_q    <= IDLE;
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        if (!freeze) begin
          if (state_q == IDLE && jump_edge) begin
            state_q  <= RISE;
            base_y_q <= pos_y_q;
            height_q <= '0;
          end
          if (tick) begin
            if (move_left) begin
              pos_x_q <= x_left_d;
              dir_q   <= 1'b0;
            end else if (move_right) begin
              pos_x_q <= x_right_d;
              dir_q   <= 1'b1;
            end
            unique case (state_q)
              IDLE: begin
                // The jump-start cycle keeps y so base_y matches the take-off row.
                if (!jump_edge) begin
                  if (move_up)        pos_y_q <= y_up_d;
                  else if (move_down) pos_y_q <= y_down_d;
                end
              end
              RISE: begin
                pos_y_q  <= y_up_d;
                height_q <= height_d;
                if (rise_done) state_q <= FALL;
              end
              FALL: begin
                pos_y_q <= y_fall_d;
                if (y_fall_d == base_y_q) state_q <= IDLE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      end
    end
  end

  assign warp_ack = warp_ack_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign dir      = dir_q;
  assign jumping  = (state_q != IDLE);

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Parametrised player-sprite position controller for the game core. It turns held direction keys into rate-limited, bounds-clamped position updates and runs a timed jump (rise/fall) state machine. Stage changes reposition the sprite through a warp handshake. It sits between the keyboard decoder and the sprite renderer / collision logic.

## Interface
- XW, 10, width of x coordinate
- YW, 10, width of y coordinate
- X_MIN, 0, leftmost legal pos_x
- X_MAX, 620, rightmost legal pos_x
- Y_MIN, 0, topmost legal pos_y
- Y_MAX, 460, bottommost legal pos_y
- STEP, 1, pixels moved per motion tick
- TICK_DIV, 1, clk cycles per motion tick (≥1)
- JUMP_H, 40, jump apex height in pixels
- RST_X, 320, reset x
- RST_Y, 240, reset y
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- freeze  in  1  level; blocks key motion and jump start (fail/success/cutscene)
- key_left, key_right, key_up, key_down  in  1 each  held-key levels
- key_jump  in  1  held-key level; jump starts on rising edge
- warp_valid  in  1  request to place sprite at warp_x/warp_y
- warp_x  in  XW  warp target x
- warp_y  in  YW  warp target y
- warp_ack  out  1  one-cycle pulse, warp applied
- pos_x  out  XW  sprite left coordinate
- pos_y  out  YW  sprite top coordinate
- dir  out  1  facing: 0 left, 1 right
- jumping  out  1  high while FSM is in RISE or FALL

## Operation
- Tick counter: counts 0..TICK_DIV-1, free-running; tick = (count == TICK_DIV-1). Cleared by rst and by warp acceptance.
- Per-cycle priority: rst > warp > freeze > motion.
- Warp: when warp_valid=1, accept in that cycle, even if frozen.
  - pos <= clamp(warp_x, warp_y).
  - FSM -> IDLE; tick counter cleared.
  - dir unchanged.
  - warp_ack=1 in the following cycle only.
  - A continuously held warp_valid re-applies every cycle.
- Horizontal motion, on tick and not frozen:
  - left only: x -= STEP, dir <= 0.
  - right only: x += STEP, dir <= 1.
  - both or neither: x and dir unchanged.
- Vertical motion (IDLE only), on tick and not frozen:
  - up only: y -= STEP.
  - down only: y += STEP.
  - both: no change.
- Arithmetic and clamping:
  - Compute in XW+1 / YW+1 bits so underflow is detected, not wrapped.
  - Clamp results to [X_MIN, X_MAX] and [Y_MIN, Y_MAX].
- Jump FSM states: IDLE, RISE, FALL.
  - IDLE -> RISE on key_jump rising edge (jump_prev register), not frozen, no warp. Latch base_y = pos_y; height = 0.
  - RISE: each tick y -= STEP, height += STEP. Go to FALL when height ≥ JUMP_H, or when y would pass Y_MIN (clamp, then FALL).
  - FALL: each tick y += STEP, clamped so y never exceeds base_y. Return to IDLE on the tick where y reaches base_y.
  - During RISE/FALL, vertical keys are ignored, horizontal keys still act, and further jump edges are ignored.
- freeze during a jump suspends all motion, including jump progress. The FSM holds its state and resumes when freeze falls.
- jumping = (state != IDLE).

## Timing
- Reset values:
  - pos_x = RST_X, pos_y = RST_Y.
  - dir = 0, jumping = 0, warp_ack = 0.
  - FSM = IDLE, tick count = 0, jump_prev = 0.
- Outputs are registered. A key sampled on a tick cycle changes pos at that clock edge, visible the next cycle.
- With TICK_DIV=1, a held key moves STEP pixels every cycle.
- Warp latency: pos valid 1 cycle after warp_valid; warp_ack is high in the same cycle pos shows the warp target.
- Full jump duration (no clamp, no freeze): 2·ceil(JUMP_H/STEP) ticks.
- rst mid-jump or mid-warp: everything returns to reset values on the next edge, and warp_ack is not issued.

## Test plan
- Reset, then hold key_right 5 cycles (STEP=1, TICK_DIV=1) -> pos_x 320→325, dir=1; add key_left simultaneously -> pos_x frozen at 325, dir stays 1.
- TICK_DIV=4, hold key_up 16 cycles from y=240 -> y=236, changing only on every 4th cycle.
- Warp to (700, 10) with X_MAX=620 -> next cycle pos=(620,10), warp_ack=1 for exactly one cycle; repeat during freeze -> same result.
- Start at y=240 with JUMP_H=40, pulse key_jump -> y falls to 200 over 40 cycles, returns to 240 over 40 more, jumping high for 80 cycles; key_down held throughout has no effect.
- Jump from y=20 -> apex clamped at Y_MIN=0, FALL starts there, lands at 20; warp issued at apex -> FSM IDLE, jumping=0 next cycle.
- Assert freeze mid-RISE for 10 cycles -> y holds; release -> jump completes with total active ticks unchanged; hold x at X_MIN with key_left -> x stays X_MIN, no wrap to 1023.
